// File: rtl/fetch_arbiter.sv
// fetch_arbiter: round-robin arbiter sharing one instruction-fetch memory
// port among N_REQ cores. One transaction at a time: grant in IDLE, read
// through ISSUE/WAIT, one-cycle response pulse in RESP. Misaligned addresses
// are answered with an error and never reach memory. Hung memory reads end
// with an error response after TIMEOUT cycles.
//
// Ports
//   clock, reset              rising-edge clock, synchronous active-high reset
//   req_valid/req_addr        per-core request, address i at [i*ADDR_W +: ADDR_W]
//   req_ready                 one-hot acceptance (combinational, IDLE only)
//   rsp_valid/rsp_data/rsp_err one-cycle response to the owning core
//   mem_req/mem_addr/mem_ack  memory read request handshake
//   mem_rvalid/mem_rdata      memory read data
//   busy                      high whenever not IDLE
module fetch_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_ack,
  input  logic                      mem_rvalid,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [9:0] TLIM = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             r_state, w_state_nxt;
  logic [OW-1:0]      r_owner, r_ptr, w_win, w_cand;
  logic [OW:0]        w_sum;
  logic               w_found, w_mis, w_tout;
  logic [ADDR_W-1:0]  r_addr, w_win_addr;
  logic [DATA_W-1:0]  r_data;
  logic               r_err;
  logic [9:0]         r_tcnt;

  // Winner search: first requester at or above r_ptr, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (OW+1)'(k);
      if (w_sum >= (OW+1)'(N_REQ)) w_sum = w_sum - (OW+1)'(N_REQ);
      w_cand = w_sum[OW-1:0];
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_win_addr = req_addr[w_win*ADDR_W +: ADDR_W];
  assign w_mis      = (w_win_addr[1:0] != 2'b00);
  // ">=" rather than "==": an ack on the last counted ISSUE cycle moves to
  // WAIT with the counter already past the limit, and that WAIT must still
  // end on its first cycle unless data arrives.
  assign w_tout     = (r_tcnt >= TLIM);

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_data    = '0;
    rsp_err     = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          req_ready[w_win] = 1'b1;
          w_state_nxt      = w_mis ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_req  = 1'b1;
        mem_addr = r_addr;
        if (mem_ack)     w_state_nxt = S_WAIT;
        else if (w_tout) w_state_nxt = S_RESP;
      end
      S_WAIT: begin
        if (mem_rvalid || w_tout) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid[r_owner] = 1'b1;
        rsp_data           = r_data;
        rsp_err            = r_err;
        w_state_nxt        = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_tcnt  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner <= w_win;
            r_addr  <= w_win_addr;
            r_tcnt  <= '0;
            if (w_mis) begin
              r_err  <= 1'b1;
              r_data <= '0;
            end
          end
        end
        S_ISSUE: begin
          r_tcnt <= r_tcnt + 10'd1;
          if (!mem_ack && w_tout) begin
            r_err  <= 1'b1;
            r_data <= '0;
          end
        end
        S_WAIT: begin
          r_tcnt <= r_tcnt + 10'd1;
          if (mem_rvalid) begin
            r_data <= mem_rdata;
            r_err  <= 1'b0;
          end else if (w_tout) begin
            r_err  <= 1'b1;
            r_data <= '0;
          end
        end
        S_RESP: begin
          r_ptr <= (r_owner == OW'(N_REQ-1)) ? '0 : r_owner + OW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_arbiter.sv
// Bench for fetch_arbiter: randomized cores and memory, checked every cycle
// against a transaction-level model that predicts grant order and response
// timing from per-transaction ack/data delays with plain arithmetic.
module tb_fetch_arbiter;
  localparam int N = 4, AW = 32, DW = 32, T = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid, req_ready, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [DW-1:0]     rsp_data, mem_rdata;
  logic              rsp_err, mem_req, mem_ack, mem_rvalid, busy;
  logic [AW-1:0]     mem_addr;

  always #5 clock = ~clock;

  fetch_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // model state
  int            cyc = 0;
  bit            pend [N];
  logic [AW-1:0] paddr [N];
  int            mptr = 0;
  bit            gen_en = 1'b0;
  int            force_a = -1, force_b = -1;
  bit            t_act = 1'b0, t_mis, t_acked, t_err;
  int            t_own, t_acc, t_a, t_b, t_rsp, t_iss_end;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_rdata, t_exp;

  function automatic logic [AW-1:0] mk_addr();
    logic [AW-1:0] a;
    a = $urandom();
    if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
    else                           a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic accept(input int w);
    int a, b, tlim, sel;
    t_act = 1'b1; t_own = w; t_acc = cyc; t_addr = paddr[w];
    t_mis = (paddr[w][1:0] != 2'b00);
    if (force_a >= 0) begin
      a = force_a; b = force_b;
    end else begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       begin a = 0; b = 0; end
        1:       begin a = $urandom_range(0, T+1); b = $urandom_range(0, T); end
        2:       begin a = $urandom_range(0, T-2); b = T-2-a; end  // data on last allowed cycle
        default: begin a = $urandom_range(0, T-2); b = T-1-a; end  // one cycle too late
      endcase
    end
    t_a = a; t_b = b;
    t_rdata = $urandom();
    if (t_mis) begin
      t_acked = 1'b0; t_iss_end = cyc; t_rsp = cyc + 1; t_err = 1'b1; t_exp = '0;
    end else if (a > T-1) begin
      t_acked = 1'b0; t_iss_end = cyc + T; t_rsp = cyc + T + 1; t_err = 1'b1; t_exp = '0;
    end else begin
      t_acked = 1'b1; t_iss_end = cyc + 1 + a;
      tlim = (a + 1 > T - 1) ? a + 1 : T - 1;
      if (a + 1 + b <= tlim) begin
        t_rsp = cyc + 3 + a + b; t_err = 1'b0; t_exp = t_rdata;
      end else begin
        t_rsp = cyc + 2 + tlim; t_err = 1'b1; t_exp = '0;
      end
    end
    pend[w] = 1'b0;
  endtask

  task automatic step(input bit rst);
    bit idle, in_iss, in_wait, rv_hit;
    int w;
    logic [N-1:0] e_rdy, e_rv;
    idle = !t_act || cyc > t_rsp;
    if (gen_en)
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 2) == 0) begin pend[i] = 1'b1; paddr[i] = mk_addr(); end
        end else if (idle && $urandom_range(0, 19) == 0) pend[i] = 1'b0;
      end
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_addr[i*AW +: AW] = pend[i] ? paddr[i] : AW'($urandom());
    end
    in_iss  = t_act && !t_mis && cyc >= t_acc + 1 && cyc <= t_iss_end;
    in_wait = t_act && t_acked && cyc >= t_acc + 2 + t_a && cyc <= t_rsp - 1;
    rv_hit  = t_act && t_acked && cyc == t_acc + 2 + t_a + t_b;
    mem_ack    = in_iss ? (t_acked && cyc == t_acc + 1 + t_a) : ($urandom_range(0, 3) == 0);
    mem_rvalid = in_wait ? rv_hit : (rv_hit || $urandom_range(0, 3) == 0);
    mem_rdata  = rv_hit ? t_rdata : DW'($urandom());
    reset = rst;
    #4;
    w = -1;
    if (idle)
      for (int k = 0; k < N; k++)
        if (w < 0 && pend[(mptr + k) % N]) w = (mptr + k) % N;
    e_rdy = '0; if (w >= 0) e_rdy[w] = 1'b1;
    e_rv  = '0; if (t_act && cyc == t_rsp) e_rv[t_own] = 1'b1;
    chk("req_ready", req_ready, e_rdy);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("rsp_data",  rsp_data,  (t_act && cyc == t_rsp) ? t_exp : '0);
    chk("rsp_err",   rsp_err,   t_act && cyc == t_rsp && t_err);
    chk("mem_req",   mem_req,   in_iss);
    chk("mem_addr",  mem_addr,  in_iss ? t_addr : '0);
    chk("busy",      busy,      t_act && cyc > t_acc && cyc <= t_rsp);
    if (rst) begin
      t_act = 1'b0; mptr = 0;
    end else begin
      if (t_act && cyc == t_rsp) mptr = (t_own + 1) % N;
      if (w >= 0) accept(w);
    end
    @(posedge clock); #1;
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && t_act && cyc <= t_rsp; i++) step(1'b0);
    chk("drain_idle", (t_act && cyc <= t_rsp), 1'b0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; paddr[i] = '0; end
    reset = 1'b1; req_valid = '0; req_addr = '0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    step(1'b1);                          // reset state: all outputs zero
    gen_en = 1'b1;
    for (int i = 0; i < 1500; i++) step(1'b0);

    // directed: grant core 1 (ptr -> 2), then abandon core 2 mid-WAIT
    gen_en = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drain();
    force_a = 0; force_b = 0;
    pend[1] = 1'b1; paddr[1] = 32'h100;
    step(1'b0);
    drain();
    force_b = 50;
    pend[2] = 1'b1; paddr[2] = 32'h200;
    step(1'b0);                          // accept
    step(1'b0);                          // ISSUE with ack
    step(1'b0);                          // WAIT
    step(1'b1);                          // reset while in WAIT
    force_a = -1; force_b = -1;
    for (int i = 0; i < 4; i++) step(1'b0);  // quiet: stray rvalid ignored
    for (int i = 0; i < N; i++) begin pend[i] = 1'b1; paddr[i] = 32'h1000 + 32'(i*16); end
    for (int i = 0; i < 20; i++) step(1'b0); // core 0 first, then 1, 2, 3

    gen_en = 1'b1;
    for (int i = 0; i < 500; i++) step(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_arbiter.md
# fetch_arbiter

Round-robin arbiter that shares the single instruction-fetch memory port among the four cores of `SparCool`. Each core raises a word-fetch request. The arbiter grants one requester at a time, drives one memory read transaction, and returns the data to the winning core. It sits between the cores' fetch stages and the RAM model. It also rejects misaligned addresses and ends hung memory transactions with a timeout.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (cores); must be ≥2.
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: fetch word width.
- `TIMEOUT`, 255: maximum cycles spent in ISSUE+WAIT before an error response; range 1..1023.

Ports:
- `clock`, in, 1: the single clock; all logic is rising-edge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, N_REQ: request from core i, bit i.
- `req_addr`, in, N_REQ*ADDR_W: address of core i at `[i*ADDR_W +: ADDR_W]`.
- `req_ready`, out, N_REQ: one-hot acceptance, combinational, only in IDLE.
- `rsp_valid`, out, N_REQ: one-hot, registered, one-cycle response pulse.
- `rsp_data`, out, DATA_W: response word, valid with `rsp_valid`, shared by all cores.
- `rsp_err`, out, 1: response is an error (misaligned or timeout), valid with `rsp_valid`.
- `mem_req`, out, 1: memory read request.
- `mem_addr`, out, ADDR_W: memory read address.
- `mem_ack`, in, 1: memory accepted `mem_req` this cycle.
- `mem_rvalid`, in, 1: read data valid.
- `mem_rdata`, in, DATA_W: read data.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Registers:
  - `owner` (log2 N_REQ bits)
  - `addr_q`
  - `data_q`
  - `err_q`
  - round-robin pointer `ptr`
  - timeout counter `tcnt` (10 bits)
- **IDLE**
  - The winner is the first set bit of `req_valid`, searching from index `ptr` upward with wrap.
  - If there is a winner: assert `req_ready[winner]`, latch `owner` and `addr_q`, clear `tcnt`.
  - If `addr[1:0]` ≠ 0: set `err_q=1`, `data_q=0`, go to RESP. No memory access occurs.
  - Otherwise: go to ISSUE.
- **ISSUE**
  - `mem_req=1`, `mem_addr=addr_q`.
  - On `mem_ack`: go to WAIT.
  - `tcnt` increments each cycle.
- **WAIT**
  - On `mem_rvalid`: `data_q=mem_rdata`, `err_q=0`, go to RESP.
  - `tcnt` increments each cycle.
- **Timeout**
  - In ISSUE or WAIT, when `tcnt == TIMEOUT-1` and no completing event occurs that cycle: `err_q=1`, `data_q=0`, go to RESP.
  - A completing event (`mem_ack` in ISSUE, `mem_rvalid` in WAIT) in that same cycle wins over the timeout.
- **RESP**
  - `rsp_valid[owner]=1`, `rsp_data=data_q`, `rsp_err=err_q` for exactly one cycle.
  - `ptr <= (owner+1) mod N_REQ`, go to IDLE.
- `mem_rvalid` is ignored outside WAIT; `mem_ack` is ignored outside ISSUE.
- Requesters hold `req_valid` and `req_addr` stable until `req_ready`. A requester may withdraw `req_valid` before it is granted.
- At most one outstanding memory transaction at any time.

## Timing
- Reset values:
  - state=IDLE, `ptr`=0, `owner`=0, `tcnt`=0, `addr_q`=0, `data_q`=0, `err_q`=0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `mem_req`=0, `mem_addr`=0, `busy`=0.
- Reset in any state abandons the transaction. No `rsp_valid` is issued for it; a later `mem_rvalid` is ignored.
- Best-case latency: accept at cycle 0, `mem_req` at 1 with `mem_ack` at 1, `mem_rvalid` at 2, `rsp_valid` at 3. Back-to-back grants are then spaced 4 cycles apart.
- Misaligned request: accept at cycle 0, `rsp_valid` with `rsp_err=1` at cycle 1.
- Timeout: `rsp_valid` arrives `TIMEOUT+1` cycles after acceptance.
- `req_ready` is never asserted outside IDLE, so a new grant is never issued in the RESP cycle. The earliest next grant is the cycle after RESP.
- `mem_req` stays asserted continuously in ISSUE until `mem_ack`.

## Test plan
- **Single request:** reset, core 2 requests address 0x100; `mem_ack` on the first cycle, `mem_rvalid` one cycle later with 0xDEADBEEF. Required: `rsp_valid`=4'b0100, `rsp_data`=0xDEADBEEF, `rsp_err`=0, 3 cycles after acceptance.
- **Round-robin:** all four cores request continuously, memory responds immediately. Required: grant order 0,1,2,3,0, with 4-cycle spacing.
- **Fairness after a grant:** `ptr`=2, cores 0 and 3 request. Required: core 3 granted first, then core 0.
- **Misaligned:** core 1 requests 0x102. Required: `mem_req` never asserted, `rsp_valid`=4'b0010 with `rsp_err`=1 and `rsp_data`=0 one cycle after acceptance.
- **Timeout:** `TIMEOUT`=8, memory acks but never asserts `rvalid`. Required: `rsp_err`=1 at cycle 9; a late `mem_rvalid` in IDLE is ignored. A second case asserts `rvalid` on the final counted cycle and must return the data with `rsp_err`=0.
- **Reset mid-WAIT:** reset asserted while in WAIT. Required: all outputs 0 the next cycle, no `rsp_valid`, and the next request is served normally from `ptr`=0.
